magic_packet_injector: RTL and testbench

// Transmit-side companion to the data-integrity scoreboard. Drives push/pop/start/data into a FIFO under test.

---
 rtl/magic_packet_injector.sv | 101 ++++++++++
 tb/tb_magic_packet_injector.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/magic_packet_injector.sv
// Stimulus generator for a FIFO under test: pushes a sequence-numbered stream, injects one
// magic packet flagged by start, tracks how many packets sit ahead of it, and pulses done when it leaves.
module magic_packet_injector #(
  parameter int               DEPTH        = 8,
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] MAGIC        = 8'hA5,
  parameter int               INJECT_AFTER = 3,
  parameter int               CNTWID       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic              full,
  input  logic              empty,
  output logic              push,
  output logic              pop,
  output logic [WIDTH-1:0]  data,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic [CNTWID-1:0] ahead
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_INJECT,
    S_POST,
    S_DONE
  } state_t;

  localparam logic [15:0] PRE_LAST = (INJECT_AFTER == 0) ? 16'd0 : 16'(INJECT_AFTER - 1);

  state_t            state_q, state_d;
  logic [CNTWID-1:0] occ_q;
  logic [CNTWID-1:0] ahead_q;
  logic [WIDTH-1:0]  seq_q;
  logic [WIDTH-1:0]  seq_inc;
  logic [WIDTH-1:0]  seq_next;
  logic [15:0]       pre_cnt_q;
  logic              push_ok;

  // NOTE: every output and next-state value gets a default before the case statement,
  // so no path through this block can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    push_ok  = (state_q == S_PRE) || (state_q == S_INJECT) || (state_q == S_POST);
    busy     = push_ok;
    push     = push_req & ~full & ~rst & push_ok;
    pop      = pop_req & ~empty & ~rst & (state_q != S_IDLE);
    start    = push & (state_q == S_INJECT);
    data     = (state_q == S_INJECT) ? MAGIC : seq_q;
    // Normal data never takes the magic value: step over it.
    seq_inc  = seq_q + WIDTH'(1);
    seq_next = (seq_inc == MAGIC) ? seq_q + WIDTH'(2) : seq_inc;

    case (state_q)
      S_IDLE:   if (go) state_d = (INJECT_AFTER == 0) ? S_INJECT : S_PRE;
      S_PRE:    if (push && pre_cnt_q == PRE_LAST) state_d = S_INJECT;
      S_INJECT: if (push) state_d = S_POST;
      S_POST:   if (pop && ahead_q == '0) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      occ_q     <= '0;
      ahead_q   <= '0;
      seq_q     <= '0;
      pre_cnt_q <= '0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == S_POST) && pop && (ahead_q == '0);

      if (push && !pop)      occ_q <= occ_q + CNTWID'(1);
      else if (pop && !push) occ_q <= occ_q - CNTWID'(1);

      if (push && state_q != S_INJECT) seq_q <= seq_next;

      if (state_q == S_IDLE && go)      pre_cnt_q <= '0;
      else if (state_q == S_PRE && push) pre_cnt_q <= pre_cnt_q + 16'd1;

      // A pop in the magic-push cycle removes an older entry, never the magic one.
      if (state_q == S_INJECT && push)
        ahead_q <= occ_q - CNTWID'(pop);
      else if (state_q == S_POST && pop && ahead_q != '0)
        ahead_q <= ahead_q - CNTWID'(1);
    end
  end

  assign ahead = ahead_q;

endmodule

// File: tb/tb_magic_packet_injector.sv
// Bench for magic_packet_injector: emulates the FIFO under test with a queue and compares every
// cycle against a run-level model (normal count, magic position in the queue, done timing).
module tb_magic_packet_injector;

  localparam int          DEPTH        = 8;
  localparam int          WIDTH        = 8;
  localparam int          INJECT_AFTER = 3;
  localparam int          CNTWID       = $clog2(DEPTH) + 1;
  localparam logic [7:0]  MAGIC        = 8'hA5;

  logic              clk;
  logic              rst;
  logic              go;
  logic              push_req;
  logic              pop_req;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  data;
  logic              start;
  logic              busy;
  logic              done;
  logic [CNTWID-1:0] ahead;

  int tests_run    = 0;
  int tests_failed = 0;

  // FIFO under test and run-level reference model
  logic [7:0] fifo_q[$];
  bit         m_run;       // run active: from cycle after go until the magic packet is popped
  bit         m_drain;     // the single cycle after the magic pop
  bit         m_magic_in;  // magic packet currently held in the FIFO
  int         m_nnorm;     // normal packets pushed in this run
  int         m_seq;       // next normal sequence value

  magic_packet_injector #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .MAGIC(MAGIC), .INJECT_AFTER(INJECT_AFTER), .CNTWID(CNTWID)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .push_req(push_req), .pop_req(pop_req),
    .full(full), .empty(empty), .push(push), .pop(pop), .data(data),
    .start(start), .busy(busy), .done(done), .ahead(ahead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    m_run      = 1'b0;
    m_drain    = 1'b0;
    m_magic_in = 1'b0;
    m_nnorm    = 0;
    m_seq      = 0;
  endtask

  // One clock cycle: drive at negedge, compare 1 time unit later, advance model/FIFO.
  task automatic step(input bit g, input bit r, input bit pr, input bit qr);
    bit         was_idle, slot, e_push, e_pop;
    int         e_data, pos;
    logic [7:0] popped;
    @(negedge clk);
    go       = g;
    rst      = r;
    push_req = pr;
    pop_req  = qr;
    full     = (fifo_q.size() >= DEPTH);
    empty    = (fifo_q.size() == 0);
    #1;
    was_idle = !m_run && !m_drain;
    slot     = m_run && !m_magic_in && (m_nnorm == INJECT_AFTER);
    e_push   = pr && !full && !r && m_run;
    e_pop    = qr && !empty && !r && (m_run || m_drain);
    e_data   = slot ? int'(MAGIC) : m_seq;

    check("push",  push,  e_push);
    check("pop",   pop,   e_pop);
    check("start", start, e_push && slot);
    check("data",  data,  e_data);
    check("busy",  busy,  m_run);
    check("done",  done,  m_drain);
    if (m_magic_in) begin
      pos = -1;
      foreach (fifo_q[i]) if (pos < 0 && fifo_q[i] == MAGIC) pos = i;
      check("ahead", ahead, pos);
    end

    if (r) begin
      model_reset();
    end else begin
      m_drain = 1'b0;
      popped  = 8'h00;
      if (pop && fifo_q.size() > 0) popped = fifo_q.pop_front();
      if (push && fifo_q.size() < DEPTH) fifo_q.push_back(data);
      if (e_pop && popped == MAGIC) begin
        m_run      = 1'b0;
        m_magic_in = 1'b0;
        m_drain    = 1'b1;
      end
      if (e_push) begin
        if (slot) begin
          m_magic_in = 1'b1;
        end else begin
          m_nnorm++;
          m_seq = (m_seq + 1) % 256;
          if (m_seq == int'(MAGIC)) m_seq = (m_seq + 1) % 256;
        end
      end
      if (g && was_idle) begin
        m_run   = 1'b1;
        m_nnorm = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; push_req = 1'b0; pop_req = 1'b0;
    full = 1'b0; empty = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_push",  push,  0);
    check("rst_pop",   pop,   0);
    check("rst_busy",  busy,  0);
    check("rst_done",  done,  0);
    check("rst_ahead", ahead, 0);
    check("rst_data",  data,  0);

    // Basic run: 0,1,2 then magic with ahead=3, drain to done; go while busy is ignored.
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    repeat (3) step(0, 0, 1, 0);
    repeat (5) step(0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0);

    // Magic pushed into an empty FIFO with a simultaneous pop request.
    step(1, 0, 0, 0);
    repeat (2) begin step(0, 0, 1, 0); step(0, 0, 0, 1); end
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);

    // Leave 5 entries behind, then a run that fills the FIFO and stalls the magic push.
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0);
    repeat (4) step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    repeat (9) step(0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0);

    // Reset in the middle of POST with push requested.
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0);
    step(0, 1, 1, 1);
    repeat (3) step(0, 0, 1, 1);

    // Randomised traffic long enough for the sequence to wrap past A5 and FF several times.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 8) == 0, ($urandom % 400) == 0,
           ($urandom % 100) < 60, ($urandom % 100) < 50);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
